vga_arbiter: RTL
================

# vga_arbiter

Shares the single pixel-write port of `vga_adapter` (160x120, 3-bit colour) between several drawing engines (fillscreen, circle, Reuleaux triangle). Accepts level job requests, starts one engine at a time using the engines' start/done handshake, and steers only the granted engine's pixel bus to the adapter. Grants are round-robin, one whole job per grant, and off-screen plots are suppressed. It sits between the engine instances and `vga_adapter` in the task top level.

## Interface
Parameters:
- `NREQ`, 3: number of engines/requesters, 2..8.

Ports:
- `clk`  in  1: system clock (CLOCK_50).
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: level job request per engine, held high until the matching `ack`.
- `ack`  out  NREQ: one-cycle pulse when requester i's job finishes.
- `grant`  out  NREQ: one-hot, identifies the current owner; all zero when idle.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `eng_start`  out  NREQ: start to engine i, held high from grant until its done is seen.
- `eng_done`  in  NREQ: done from engine i, a level.
- `eng_x`  in  NREQ*8: packed x per engine; engine i occupies bits [8i+7:8i].
- `eng_y`  in  NREQ*7: packed y, same packing scheme.
- `eng_colour`  in  NREQ*3: packed colour, same packing scheme.
- `eng_plot`  in  NREQ: plot strobe per engine.
- `vga_x`  out  8: to the adapter.
- `vga_y`  out  7: to the adapter.
- `vga_colour`  out  3: to the adapter.
- `vga_plot`  out  1: to the adapter.

## Operation
- The FSM has three states: IDLE, RUN and RELEASE.
- IDLE:
  - If `req` is non-zero, pick a winner `g` with `rr_pick`: the first set bit at or after `last+1`, mod NREQ.
  - Set `grant[g]` and `eng_start[g]`, then go to RUN.
- RUN:
  - Pixel bus is forwarded from engine `g` only.
  - When `eng_done[g]` is high: clear `eng_start[g]`, pulse `ack[g]`, set `last<=g`, go to RELEASE.
- RELEASE:
  - `grant[g]` stays high; `vga_plot` is forced 0.
  - When `eng_done[g]` is low, clear `grant` and go to IDLE.
- Pixel path:
  - Registered; `vga_plot` = `eng_plot[g]` AND x<160 AND y<120 AND state==RUN.
  - x, y and colour are registered unconditionally from `g`.
- Ignored inputs: `eng_plot`/`eng_done` from non-granted engines have no effect. `req` falling during RUN does not abort the job.
- Re-requests: a requester holding `req` after its `ack` is treated as a new job. Round-robin guarantees every other pending requester is served first.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - `last` resets to NREQ-1, so requester 0 wins the first arbitration.
  - Reset mid-job abandons the job with no `ack`.

## Timing
- Request to start: `req` high in IDLE at edge k gives `eng_start`/`grant` high after edge k (1 cycle).
- Pixel latency: `eng_*` at edge k appears on `vga_*` after edge k+1, i.e. exactly 1 cycle. No pixel is dropped or duplicated while in RUN.
- Done handling: `eng_done[g]` sampled high at edge k means `eng_start[g]` is low and `ack[g]` pulses for one cycle after edge k.
- Release: `eng_done[g]` low at edge m means `grant` is 0 after edge m. The next grant can follow at edge m+1.
- Minimum gap between consecutive jobs: 2 idle cycles on `eng_start`.
- An engine whose done is already high at grant completes in RUN after 1 cycle; this is legal.
- No timeout: a hung engine holds the port indefinitely.

## Structure
- Package `vga_arb_pkg`:
  - state enum `arb_state_t` {IDLE, RUN, RELEASE};
  - constants `VGA_W=160`, `VGA_H=120`, `XW=8`, `YW=7`, `CW=3`.
- Sub-module `rr_pick`: combinational round-robin picker, parameter NREQ; inputs `req`, `last`; outputs one-hot `gnt`, index `idx`, `any`.
- Top level instantiates engines → `vga_arbiter` → `vga_adapter`. `rst_n` comes from KEY[3].

## Test plan
- Single request: `req`=001 with an engine model that plots (5,7,colour 3) then asserts done. Expect `eng_start`=001 one cycle later, then `vga_x`=5, `vga_y`=7, `vga_colour`=3, `vga_plot`=1 one cycle after the plot, then one `ack`=001 pulse and `grant`=000 after done falls.
- Contention: `req`=111 held after reset. Expect grant order 001, 010, 100, 001, and no overlap of `eng_start` bits.
- Isolation: the non-granted engine toggles `eng_plot` with x=20 during another engine's RUN. Expect `vga_plot` to stay 0 for those pixels and `vga_x` to never show 20.
- Off-screen: the granted engine plots (160,10) and then (10,120). Expect `vga_plot`=0 for both; (159,119) gives `vga_plot`=1.
- Reset mid-job: assert `rst_n`=0 during RUN. Expect all outputs 0 immediately (asynchronously) and no `ack`. After release with `req`=110, requester 1 is granted first.
- Immediate done: the engine holds done high at grant. Expect RUN to last 1 cycle, `ack` to pulse once, and RELEASE to wait until done drops.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA pixel-port arbiter.
package vga_arb_pkg;

  localparam int unsigned VGA_W = 160;
  localparam int unsigned VGA_H = 120;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // One pixel as carried on the adapter write port.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } vga_pix_t;

endpackage

// File: rtl/vga_arbiter_if.sv
// Engine-side and adapter-side buses of the VGA arbiter.
interface vga_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [NREQ-1:0]    eng_start;
  logic [NREQ-1:0]    eng_done;
  logic [NREQ*XW-1:0] eng_x;
  logic [NREQ*YW-1:0] eng_y;
  logic [NREQ*CW-1:0] eng_colour;
  logic [NREQ-1:0]    eng_plot;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;
  logic               vga_plot;

  // Arbiter side.
  modport slave (
    input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
    output ack, grant, busy, eng_start, vga_x, vga_y, vga_colour, vga_plot
  );

  // Engines plus adapter side.
  modport master (
    output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
    input  ack, grant, busy, eng_start, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/vga_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1.
module rr_pick #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] pos;
  logic          hit;

  // Scan requesters starting just after the previous winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    pos = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = IW'((32'(last) + k) % NREQ);
      if (!hit && req[pos]) begin
        hit      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/vga_arbiter.sv
// Round-robin owner of the single vga_adapter pixel port, one job per grant.
module vga_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_arbiter_if.slave   bus
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t      state, state_n;
  logic [IW-1:0]   g, g_n;
  logic [IW-1:0]   last, last_n;
  logic [NREQ-1:0] grant_n, start_n, ack_n;
  logic            busy_n, plot_n;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            own_done, own_plot;
  vga_pix_t        own_pix;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Signals of the current owner only; everything else is ignored.
  always_comb begin
    own_done       = bus.eng_done[g];
    own_plot       = bus.eng_plot[g];
    own_pix.x      = bus.eng_x[32'(g)*XW +: XW];
    own_pix.y      = bus.eng_y[32'(g)*YW +: YW];
    own_pix.colour = bus.eng_colour[32'(g)*CW +: CW];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n = state;
    g_n     = g;
    last_n  = last;
    grant_n = bus.grant;
    start_n = bus.eng_start;
    ack_n   = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          g_n     = pick_idx;
          grant_n = pick_gnt;
          start_n = pick_gnt;
          state_n = RUN;
        end
      end
      RUN: begin
        if (own_done) begin
          start_n = '0;
          ack_n   = bus.grant;
          last_n  = g;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        // Hold grant until the engine drops done so it cannot be re-armed early.
        if (!own_done) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        start_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
    plot_n = own_plot && (own_pix.x < XW'(VGA_W)) && (own_pix.y < YW'(VGA_H)) &&
             (state == RUN);
  end

  // State, handshake and pixel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      g              <= '0;
      last           <= IW'(NREQ - 1);
      bus.grant      <= '0;
      bus.eng_start  <= '0;
      bus.ack        <= '0;
      bus.busy       <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      state          <= state_n;
      g              <= g_n;
      last           <= last_n;
      bus.grant      <= grant_n;
      bus.eng_start  <= start_n;
      bus.ack        <= ack_n;
      bus.busy       <= busy_n;
      bus.vga_x      <= own_pix.x;
      bus.vga_y      <= own_pix.y;
      bus.vga_colour <= own_pix.colour;
      bus.vga_plot   <= plot_n;
    end
  end

endmodule
